// File: rtl/matmul_result_drain.sv
// matmul_result_drain
//
// Downstream stage of the NxN pipelined matrix multiplier. A start pulse holds
// the multiplier's enable for LATENCY cycles, then all N*N results are
// snapshotted into a local buffer in one edge and streamed out row-major over
// a valid/ready interface. This block is the sole owner of mm_enable, and it
// isolates the array from a slow consumer.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous, active-low; low clears all state immediately
//   start      - request one multiply-and-drain (sampled only in IDLE)
//   mm_enable  - enable to the multiplier array (high for LATENCY cycles)
//   matmul     - N*N multiplier results, row-major, 2*BitWidth each
//   out_valid  - out_data holds a valid element
//   out_ready  - consumer accepts the current element
//   out_data   - current element
//   out_index  - row-major index (i*N+j) of out_data
//   out_last   - current element is index N*N-1
//   busy       - block is not idle
//   done       - one-cycle pulse after the final transfer

module matmul_result_drain #(
  parameter int N        = 3,
  parameter int BitWidth = 8,
  parameter int LATENCY  = 2*N+1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        mm_enable,
  input  logic [2*BitWidth-1:0]       matmul [0:N*N-1],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*BitWidth-1:0]       out_data,
  output logic [$clog2(N*N)-1:0]      out_index,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int DataW = 2*BitWidth;
  localparam int IdxW  = $clog2(N*N);
  // One extra value of headroom keeps the counter at least one bit wide
  // even when LATENCY is 1.
  localparam int CntW  = $clog2(LATENCY+1);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(N*N-1);
  localparam logic [CntW-1:0] LastCnt = CntW'(LATENCY-1);

  typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

  state_t            state;
  logic [CntW-1:0]   counter;
  logic [IdxW-1:0]   index;
  logic [DataW-1:0]  buffer [0:N*N-1];

  // Main FSM. mm_enable, out_valid and busy are registered alongside the
  // state so they come straight off flops and cannot glitch while the state
  // encoding changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= '0;
      index     <= '0;
      mm_enable <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int k = 0; k < N*N; k++) begin
        buffer[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= WAIT;
            counter   <= '0;
            mm_enable <= 1'b1;
            busy      <= 1'b1;
          end
        end
        WAIT: begin
          // The whole result array is captured in the single edge where the
          // enable window closes; the buffer is never written otherwise.
          if (counter == LastCnt) begin
            for (int k = 0; k < N*N; k++) begin
              buffer[k] <= matmul[k];
            end
            index     <= '0;
            state     <= STREAM;
            mm_enable <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (index == LastIdx) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              index <= index + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          mm_enable <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Element outputs are pure reads of registers, so they hold stable for as
  // long as the consumer stalls.
  assign out_data  = buffer[index];
  assign out_index = index;
  assign out_last  = out_valid && (index == LastIdx);

endmodule

// File: tb/tb_matmul_result_drain.sv
// tb_matmul_result_drain
//
// Scoreboard bench for matmul_result_drain (N=3, BitWidth=8). Stimulus pushes
// the expected element stream into a queue when a run is issued; a monitor
// pops and compares on every valid/ready handshake, and also watches stall
// stability, mm_enable cycles and done pulses.

module tb_matmul_result_drain;

  localparam int N  = 3;
  localparam int NN = N*N;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mm_enable;
  logic [15:0] matmul [0:NN-1];
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  int   errors;
  int   checks;
  exp_t exp_q [$];

  int   mm_count;
  int   done_count;
  int   xfer_count;

  logic bp_mode;
  logic ready_level;

  matmul_result_drain #(.N(N), .BitWidth(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mm_enable (mm_enable),
    .matmul    (matmul),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Expected stream for a matrix whose element k is base + k*step.
  task automatic pushExpected(input logic [15:0] base, input logic [15:0] step);
    exp_t e;
    for (int k = 0; k < NN; k++) begin
      e.data = base + 16'(k) * step;
      e.idx  = 4'(k);
      e.last = (k == NN-1);
      exp_q.push_back(e);
    end
  endtask

  task automatic driveMatrix(input logic [15:0] base, input logic [15:0] step);
    for (int k = 0; k < NN; k++) begin
      matmul[k] = base + 16'(k) * step;
    end
  endtask

  // Pulse start for one edge; returns 1ns after the sampling edge E0.
  task automatic applyStimulus();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits (bounded) for done; returns at the negedge of the done cycle.
  task automatic waitDone(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) break;
    end
    checkOutput({name, "_done_seen"}, 32'(done), 32'd1);
    checkOutput({name, "_busy_in_done"}, 32'(busy), 32'd0);
  endtask

  // out_ready driver: either a fixed level or the 1,0,0,1 stall pattern.
  initial begin
    logic [3:0] pat;
    int         ptr;
    pat = 4'b1001;
    ptr = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        out_ready = pat[ptr % 4];
        ptr++;
      end else begin
        out_ready = ready_level;
      end
    end
  end

  // Monitor: scoreboard pops, stall stability, activity counters.
  initial begin
    exp_t        e;
    logic        prev_valid;
    logic        prev_ready;
    logic [15:0] prev_data;
    logic [3:0]  prev_index;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = '0;
    prev_index = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_valid = 1'b0;
      end else begin
        if (mm_enable) mm_count++;
        if (done) done_count++;
        if (prev_valid && !prev_ready) begin
          checkOutput("stall_valid", 32'(out_valid), 32'd1);
          checkOutput("stall_data", 32'(out_data), 32'(prev_data));
          checkOutput("stall_index", 32'(out_index), 32'(prev_index));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_xfer: got index %0d data %0h expected no transfer",
                     out_index, out_data);
          end else begin
            e = exp_q.pop_front();
            checkOutput("xfer_data", 32'(out_data), 32'(e.data));
            checkOutput("xfer_index", 32'(out_index), 32'(e.idx));
            checkOutput("xfer_last", 32'(out_last), 32'(e.last));
          end
          xfer_count++;
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
        prev_index = out_index;
      end
    end
  end

  initial begin
    int mm_base;
    int done_base;
    int xfer_base;
    errors      = 0;
    checks      = 0;
    mm_count    = 0;
    done_count  = 0;
    xfer_count  = 0;
    bp_mode     = 1'b0;
    ready_level = 1'b1;
    reset       = 1'b0;
    start       = 1'b0;
    driveMatrix(16'd0, 16'd0);

    // Reset state
    #12;
    checkOutput("rst_mm_enable", 32'(mm_enable), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_index", 32'(out_index), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Basic run: elements 1..9, ready held high, timing checks
    $display("[TB] basic run");
    driveMatrix(16'd1, 16'd1);
    pushExpected(16'd1, 16'd1);
    mm_base = mm_count;
    done_base = done_count;
    applyStimulus();
    @(negedge clk);
    checkOutput("basic_busy_e0", 32'(busy), 32'd1);
    checkOutput("basic_mm_e0", 32'(mm_enable), 32'd1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("basic_prevalid", 32'(out_valid), 32'd0);
    checkOutput("basic_mm_last", 32'(mm_enable), 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("basic_first_valid", 32'(out_valid), 32'd1);
    checkOutput("basic_mm_off", 32'(mm_enable), 32'd0);
    checkOutput("basic_first_index", 32'(out_index), 32'd0);
    waitDone("basic");
    @(negedge clk);
    checkOutput("basic_done_pulse", 32'(done), 32'd0);
    checkOutput("basic_mm_cycles", 32'(mm_count - mm_base), 32'd7);
    checkOutput("basic_done_count", 32'(done_count - done_base), 32'd1);
    checkOutput("basic_queue_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure plus capture isolation
    $display("[TB] backpressure and capture isolation");
    driveMatrix(16'h0101, 16'h1111);
    pushExpected(16'h0101, 16'h1111);
    bp_mode = 1'b1;
    applyStimulus();
    repeat (7) @(posedge clk);
    #1 driveMatrix(16'hFFFF, 16'd0);
    waitDone("bp");
    bp_mode = 1'b0;
    checkOutput("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Start while busy: pulses in WAIT and in STREAM are ignored
    $display("[TB] start while busy");
    driveMatrix(16'h0200, 16'h0003);
    pushExpected(16'h0200, 16'h0003);
    mm_base = mm_count;
    done_base = done_count;
    xfer_base = xfer_count;
    applyStimulus();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone("busy_start");
    @(negedge clk);
    repeat (10) @(negedge clk);
    checkOutput("busy_start_mm_cycles", 32'(mm_count - mm_base), 32'd7);
    checkOutput("busy_start_done_count", 32'(done_count - done_base), 32'd1);
    checkOutput("busy_start_xfers", 32'(xfer_count - xfer_base), 32'd9);
    checkOutput("busy_start_idle", 32'(busy), 32'd0);

    // Reset mid-stream after the 4th transfer, away from any edge
    $display("[TB] reset mid-stream");
    driveMatrix(16'h0300, 16'h0010);
    pushExpected(16'h0300, 16'h0010);
    xfer_base = xfer_count;
    done_base = done_count;
    applyStimulus();
    for (int i = 0; i < 100 && (xfer_count - xfer_base) < 4; i++) @(posedge clk);
    checkOutput("rst_mid_reached4", 32'(xfer_count - xfer_base), 32'd4);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_data", 32'(out_data), 32'd0);
    checkOutput("rst_mid_index", 32'(out_index), 32'd0);
    checkOutput("rst_mid_last", 32'(out_last), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_mm", 32'(mm_enable), 32'd0);
    exp_q.delete();
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_mid_idle_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_idle_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_no_done", 32'(done_count - done_base), 32'd0);

    // Back-to-back: start asserted in the done cycle
    $display("[TB] back-to-back");
    driveMatrix(16'h0F00, 16'h0001);
    pushExpected(16'h0F00, 16'h0001);
    pushExpected(16'h5000, 16'h0101);
    applyStimulus();
    waitDone("b2b_first");
    driveMatrix(16'h5000, 16'h0101);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("b2b_mm_next", 32'(mm_enable), 32'd1);
    checkOutput("b2b_busy_next", 32'(busy), 32'd1);
    waitDone("b2b_second");
    @(negedge clk);
    checkOutput("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
